agu_exec_stage: RTL



---
 rtl/agu_pkg.sv | 44 ++++
 rtl/agu_out_fifo.sv | 82 ++++++++
 rtl/agu_exec_stage.sv | 110 +++++++++++
 3 files changed

// File: rtl/agu_pkg.sv
// Shared types and constants for the AGU execute stage.
package agu_pkg;

   // RV32 load/store funct3 encodings
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // One formatted memory request as seen by the load/store unit
   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] store_data;
      logic [3:0]  byte_en;
      logic [2:0]  funct3;
      logic        is_store;
      logic [5:0]  rd_tag;
      logic        rd_tag_valid;
      logic        misaligned;
   } agu_lsq_entry_t;

   localparam int unsigned ENTRY_W = $bits(agu_lsq_entry_t);

   // Alignment or illegal-encoding fault for an access of the given funct3.
   // Unsigned variants are load-only, so a store with funct3[2] set is illegal.
   function automatic logic agu_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] addr_lo,
                                           input logic       is_store);
      logic fault;
      fault = 1'b0;
      case (funct3)
         F3_B, F3_BU: fault = 1'b0;
         F3_H, F3_HU: fault = addr_lo[0];
         F3_W:        fault = (addr_lo != 2'b00);
         default:     fault = 1'b1;
      endcase
      if (is_store && funct3[2]) begin
         fault = 1'b1;
      end
      return fault;
   endfunction

endpackage

// File: rtl/agu_out_fifo.sv
// In-order output buffer of formatted AGU requests with synchronous flush.
module agu_out_fifo
   import agu_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  agu_lsq_entry_t           push_data,
   input  logic                     pop,
   output agu_lsq_entry_t           pop_data,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic            do_push, do_pop;

   agu_lsq_entry_t  mem_q [DEPTH];

   // Guard against overflow/underflow even if the caller misbehaves
   assign do_push = push & (count_q != CntW'(DEPTH));
   assign do_pop  = pop & (count_q != '0);

   // Next-state for pointers and occupancy; flush wins over push/pop
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; cleared on reset so idle outputs read zero
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else if (!flush && do_push) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   assign pop_data = mem_q[rd_ptr_q];
   assign count    = count_q;

endmodule

// File: rtl/agu_exec_stage.sv
// AGU execute stage: effective address, alignment check, store formatting,
// buffered towards the load/store unit.
module agu_exec_stage
   import agu_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        issue_valid,
   output logic        issue_ready,
   input  logic [31:0] issue_op1_data,
   input  logic [31:0] issue_op2_data,
   input  logic [31:0] issue_agu_imm,
   input  logic [2:0]  issue_funct3,
   input  logic        issue_agu_ls,
   input  logic [5:0]  issue_rd_tag,
   input  logic        issue_rd_tag_valid,
   output logic        lsq_valid,
   input  logic        lsq_ready,
   output logic [31:0] lsq_addr,
   output logic [31:0] lsq_store_data,
   output logic [3:0]  lsq_byte_en,
   output logic [2:0]  lsq_funct3,
   output logic        lsq_is_store,
   output logic [5:0]  lsq_rd_tag,
   output logic        lsq_rd_tag_valid,
   output logic        lsq_misaligned
);

   localparam int unsigned CntW = $clog2(DEPTH) + 1;

   logic [31:0]    eff_addr;
   logic [1:0]     size;
   logic           misaligned;
   logic [3:0]     byte_en;
   logic [31:0]    store_data;
   agu_lsq_entry_t push_entry;
   agu_lsq_entry_t head_entry;
   logic [CntW-1:0] fifo_count;
   logic           push, pop;

   // Address generation and request formatting
   always_comb begin
      eff_addr   = issue_op1_data + issue_agu_imm;
      size       = issue_funct3[1:0];
      misaligned = agu_misaligned(issue_funct3, eff_addr[1:0], issue_agu_ls);
      byte_en    = 4'b0000;
      store_data = '0;

      // Faulting requests touch no lanes
      if (!misaligned) begin
         case (size)
            2'b00:   byte_en = 4'b0001 << eff_addr[1:0];
            2'b01:   byte_en = eff_addr[1] ? 4'b1100 : 4'b0011;
            2'b10:   byte_en = 4'b1111;
            default: byte_en = 4'b0000;
         endcase
      end

      // Replicate narrow store data across lanes so byte_en alone selects it
      if (issue_agu_ls) begin
         case (size)
            2'b00:   store_data = {4{issue_op2_data[7:0]}};
            2'b01:   store_data = {2{issue_op2_data[15:0]}};
            2'b10:   store_data = issue_op2_data;
            default: store_data = '0;
         endcase
      end

      push_entry.addr         = eff_addr;
      push_entry.store_data   = store_data;
      push_entry.byte_en      = byte_en;
      push_entry.funct3       = issue_funct3;
      push_entry.is_store     = issue_agu_ls;
      push_entry.rd_tag       = issue_rd_tag;
      push_entry.rd_tag_valid = issue_rd_tag_valid;
      push_entry.misaligned   = misaligned;
   end

   // No pass-through when full: a pop this cycle does not free space for a push
   assign issue_ready = (fifo_count != CntW'(DEPTH)) & ~flush & ~rst;
   assign push        = issue_valid & issue_ready;
   assign lsq_valid   = (fifo_count != '0);
   assign pop         = lsq_valid & lsq_ready;

   agu_out_fifo #(
      .DEPTH (DEPTH)
   ) u_out_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .pop_data  (head_entry),
      .count     (fifo_count)
   );

   assign lsq_addr         = head_entry.addr;
   assign lsq_store_data   = head_entry.store_data;
   assign lsq_byte_en      = head_entry.byte_en;
   assign lsq_funct3       = head_entry.funct3;
   assign lsq_is_store     = head_entry.is_store;
   assign lsq_rd_tag       = head_entry.rd_tag;
   assign lsq_rd_tag_valid = head_entry.rd_tag_valid;
   assign lsq_misaligned   = head_entry.misaligned;

endmodule
